// File: rtl/prog_sequencer_pkg.sv
// rtl/prog_sequencer_pkg.sv - shared types and constants for the program sequencer
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_REL,
    NPC_ABS,
    NPC_CALL,
    NPC_RET
  } npc_sel_t;

  localparam int unsigned START_DEFAULT = 0;

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// rtl/prog_sequencer_ret_stack.sv - parametrised LIFO holding call return addresses
module ret_stack #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_top;
  logic [AW-1:0]  w_wr_idx;
  logic [AW-1:0]  w_rd_idx;

  assign w_top    = r_sp - SPW'(1);
  assign w_wr_idx = r_sp[AW-1:0];
  assign w_rd_idx = w_top[AW-1:0];
  assign o_full   = (r_sp == SPW'(DEPTH));
  assign o_empty  = (r_sp == '0);
  assign o_dout   = o_empty ? '0 : r_mem[w_rd_idx];

  // Only the pointer is cleared; entry contents survive reset and new runs.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + SPW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= w_top;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program sequencer with run handshake, stall, jumps and call stack
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned D     = 12,
  parameter int unsigned SD    = 4,
  parameter logic [D-1:0] START = D'(START_DEFAULT)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req,
  input  logic         i_stall,
  input  logic         i_reljump,
  input  logic         i_absjump,
  input  logic         i_call,
  input  logic         i_ret,
  input  logic         i_halt,
  input  logic [D-1:0] i_target,
  output logic [D-1:0] o_prog_ctr,
  output logic         o_running,
  output logic         o_done,
  output logic         o_stk_err
);

  seq_state_t   r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;
  logic         r_stk_err;

  seq_state_t   w_next_state;
  npc_sel_t     w_npc_sel;
  logic [D-1:0] w_next_pc;
  logic         w_load_start;
  logic         w_push;
  logic         w_pop;
  logic         w_clr_stack;
  logic         w_set_err;
  logic         w_clr_err;
  logic [D-1:0] w_stk_dout;
  logic         w_stk_full;
  logic         w_stk_empty;

  ret_stack #(
    .W     (D),
    .DEPTH (SD)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr_stack),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_pc + D'(1)),
    .o_dout  (w_stk_dout),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  always_comb begin
    w_next_state = r_state;
    w_npc_sel    = NPC_HOLD;
    w_load_start = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clr_stack  = 1'b0;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_start = 1'b1;
        if (i_req) begin
          w_next_state = RUN;
          w_clr_stack  = 1'b1;
          w_clr_err    = 1'b1;
        end
      end
      RUN: begin
        // One action per unstalled cycle: halt > ret > call > absjump > reljump > sequential.
        if (!i_stall) begin
          if (i_halt) begin
            w_next_state = DONE;
          end else if (i_ret) begin
            if (w_stk_empty) begin
              w_set_err = 1'b1;
              w_npc_sel = NPC_INC;
            end else begin
              w_pop     = 1'b1;
              w_npc_sel = NPC_RET;
            end
          end else if (i_call) begin
            w_npc_sel = NPC_CALL;
            if (w_stk_full) w_set_err = 1'b1;
            else            w_push    = 1'b1;
          end else if (i_absjump) begin
            w_npc_sel = NPC_ABS;
          end else if (i_reljump) begin
            w_npc_sel = NPC_REL;
          end else begin
            w_npc_sel = NPC_INC;
          end
        end
      end
      DONE: begin
        if (!i_req) begin
          w_next_state = IDLE;
          w_load_start = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_load_start = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next_pc = r_pc;
    case (w_npc_sel)
      NPC_HOLD: w_next_pc = r_pc;
      NPC_INC:  w_next_pc = r_pc + D'(1);
      NPC_REL:  w_next_pc = r_pc + i_target;
      NPC_ABS:  w_next_pc = i_target;
      NPC_CALL: w_next_pc = i_target;
      NPC_RET:  w_next_pc = w_stk_dout;
      default:  w_next_pc = r_pc;
    endcase
    if (w_load_start) w_next_pc = START;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pc      <= START;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_stk_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_running <= (w_next_state == RUN);
      r_done    <= (w_next_state == DONE);
      if (w_clr_err)      r_stk_err <= 1'b0;
      else if (w_set_err) r_stk_err <= 1'b1;
    end
  end

  assign o_prog_ctr = r_pc;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_stk_err  = r_stk_err;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised program sequencer, the next-generation replacement for the bare program counter in the 9-bit-ISA core.
- Adds a req/done run handshake, stall support, signed relative and absolute jumps, a call/return stack of configurable depth, and halt detection.
- Sits between the control decoder (branch/call/ret/halt strobes) and instr_ROM (drives prog_ctr).

Parameters:
D, 12, program counter width in bits
SD, 4, call/return stack depth in entries (>=1)
START, 0, PC value loaded on each new run (D bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
req  input  1  run request from the test harness/host
stall  input  1  freeze PC, stack and state for this cycle
reljump  input  1  relative jump: PC += signed target
absjump  input  1  absolute jump: PC = target
call  input  1  push PC+1, PC = target
ret  input  1  pop stack into PC
halt  input  1  end of program
target  input  D  jump target or signed two's-complement offset
prog_ctr  output  D  current instruction address
running  output  1  high while in RUN
done  output  1  high while in DONE
stk_err  output  1  sticky stack overflow/underflow flag

Behaviour:
- Reset: state=IDLE, prog_ctr=START, stack empty (sp=0), running=0, done=0, stk_err=0. Reset overrides all other inputs, including mid-run and while stall=1.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: prog_ctr held at START. If req=1, then next cycle state=RUN, prog_ctr=START, stack emptied, stk_err cleared. All control strobes are ignored.
- RUN with stall=1: no state, PC, sp or stk_err change. All strobes are ignored, including halt.
- RUN with stall=0: exactly one action per cycle, in priority order halt > ret > call > absjump > reljump > sequential.
  - halt: next state=DONE; prog_ctr holds its current value.
  - ret: if sp>0, prog_ctr=stack[sp-1] and sp-=1. If sp=0 (underflow), set stk_err=1 and prog_ctr=prog_ctr+1.
  - call: if sp<SD, stack[sp]=prog_ctr+1, sp+=1, prog_ctr=target. If sp=SD (overflow), set stk_err=1, drop the push, still set prog_ctr=target.
  - absjump: prog_ctr=target.
  - reljump: prog_ctr=prog_ctr+target, target sign-extended to D bits, result modulo 2^D.
  - none: prog_ctr=prog_ctr+1, wrapping at 2^D-1 -> 0.
- req deasserted during RUN: ignored; the run ends only via halt or reset.
- DONE: done=1. prog_ctr holds the halt address. Remains in DONE while req=1. When req=0, next cycle state=IDLE, done=0, prog_ctr=START.
- Latency: req seen in IDLE -> running=1 and prog_ctr=START on the next edge. halt seen -> done=1 on the next edge.
- stk_err is sticky through DONE and IDLE. It is cleared only by reset or entry to RUN.
- Stack contents are not cleared on entry to RUN; only sp is zeroed.

Decomposition:
- Shared package:
  - state enum seq_state_t {IDLE, RUN, DONE}
  - next-PC select enum {NPC_HOLD, NPC_INC, NPC_REL, NPC_ABS, NPC_CALL, NPC_RET}
  - START default constant
- One sub-module: ret_stack, a parametrised LIFO (width D, depth SD).
  - Inputs: push, pop, din.
  - Outputs: dout (top entry), full, empty.
  - Synchronous clear of sp.
  - Simultaneous push and pop is never issued by prog_sequencer.
- Next-PC selection is combinational in prog_sequencer; a single always_ff handles state and PC.

Test Plan:
- Reset then req=1 for 1 cycle with START=0, no strobes -> running=1 next edge, prog_ctr sequence 0,1,2,3. Assert reset at prog_ctr=3 -> IDLE, prog_ctr=0 next edge.
- At prog_ctr=10: reljump with target=12'hFFD (-3) -> prog_ctr=7. At prog_ctr=12'hFFF with no strobe -> wraps to 0. absjump target=0x200 -> prog_ctr=0x200.
- At prog_ctr=5: call target=0x40 -> prog_ctr=0x40, sp=1. Then ret -> prog_ctr=6, sp=0. Nested calls from 5 and 0x40 return to 0x41, then 6.
- SD=4: five nested calls -> fifth call jumps to its target, stk_err=1, push dropped. Ret with sp=0 -> stk_err=1, prog_ctr increments. New run after req clears stk_err.
- stall=1 for 3 cycles at prog_ctr=9 with absjump asserted -> prog_ctr stays 9, sp unchanged. Release stall with absjump=1, target=0x20 -> prog_ctr=0x20.
- halt at prog_ctr=0x33 with req held -> done=1 next edge, prog_ctr=0x33 held. Drop req -> IDLE next edge, done=0, prog_ctr=START. Assert halt and call in the same cycle -> halt wins, sp unchanged.
